// File: rtl/spi_flash_wb_reader.sv
// spi_flash_wb_reader
// Read-only Wishbone B3 slave that exposes the boot SPI flash as a memory
// window. Every 32-bit read issues one SPI READ (0x03): command byte, 24-bit
// byte address, then 32 data bits clocked back MSB first (big-endian word).
//
// Parameters
//   CLK_DIV    : SCK half-period in wb_clk cycles (>= 1)
//   FLASH_BASE : byte offset added to every flash address, modulo 2^24
//   CS_HIGH    : minimum wb_clk cycles chip select stays high between transfers (>= 1)
//
// Ports
//   wb_clk, wb_rst_n          : clock, synchronous active-low reset
//   wb_adr_i[23:2]            : word address within the flash window
//   wb_cyc_i/stb_i/we_i       : Wishbone request qualifiers
//   wb_dat_o, wb_ack_o        : read data and one-cycle completion pulse
//   wb_err_o                  : one-cycle pulse rejecting a write
//   spi_sck_o/ss_n_o/mosi_o   : SPI master outputs, mode 0
//   spi_miso_i                : serial data from the flash
//
// state   | meaning
// S_IDLE  | waiting for a Wishbone request
// S_SHIFT | CS low, 64 SCK periods of command/address/data
// S_ACK   | present captured word and pulse ack, release CS
// S_GAP   | CS held high for CS_HIGH cycles before the next request
module spi_flash_wb_reader #(
  parameter int unsigned CLK_DIV    = 2,
  parameter logic [23:0] FLASH_BASE = 24'h000000,
  parameter int unsigned CS_HIGH    = 4
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic [23:2] wb_adr_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        spi_sck_o,
  output logic        spi_ss_n_o,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_ACK, S_GAP} state_t;

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GAP_W = (CS_HIGH > 1) ? $clog2(CS_HIGH) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_HIGH - 1);
  localparam logic [7:0] CMD_READ = 8'h03;

  state_t           state_q;
  logic [63:0]      tx_q;
  logic [31:0]      rx_q;
  logic [31:0]      dat_q;
  logic [DIV_W-1:0] div_q;
  logic [GAP_W-1:0] gap_q;
  logic [5:0]       bit_q;
  logic             sck_q;
  logic             ss_n_q;
  logic             ack_q;
  logic             err_q;

  logic [23:0]      addr_d;
  logic             req_d;
  logic             tick_d;

  always_comb begin
    addr_d = {wb_adr_i, 2'b00} + FLASH_BASE;
    req_d  = wb_cyc_i & wb_stb_i;
    tick_d = (div_q == DIV_LAST);
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      state_q <= S_IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      dat_q   <= '0;
      div_q   <= '0;
      gap_q   <= '0;
      bit_q   <= '0;
      sck_q   <= 1'b0;
      ss_n_q  <= 1'b1;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // err_q blocks the cycle right after an error so a master that is
          // still holding stb while it samples err does not get a second pulse.
          if (req_d && !err_q) begin
            if (wb_we_i) begin
              err_q <= 1'b1;
            end else begin
              tx_q    <= {CMD_READ, addr_d, 32'h0};
              ss_n_q  <= 1'b0;
              div_q   <= '0;
              bit_q   <= '0;
              state_q <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          if (!req_d) begin
            ss_n_q  <= 1'b1;
            sck_q   <= 1'b0;
            tx_q    <= '0;
            gap_q   <= '0;
            state_q <= S_GAP;
          end else if (tick_d) begin
            div_q <= '0;
            sck_q <= ~sck_q;
            if (!sck_q) begin
              rx_q <= {rx_q[30:0], spi_miso_i};
            end else begin
              tx_q  <= {tx_q[62:0], 1'b0};
              bit_q <= bit_q + 6'd1;
              if (bit_q == 6'd63) begin
                state_q <= S_ACK;
              end
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        S_ACK: begin
          ack_q   <= 1'b1;
          dat_q   <= rx_q;
          ss_n_q  <= 1'b1;
          tx_q    <= '0;
          gap_q   <= '0;
          state_q <= S_GAP;
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            state_q <= S_IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wb_dat_o   = dat_q;
  assign wb_ack_o   = ack_q;
  assign wb_err_o   = err_q;
  assign spi_sck_o  = sck_q;
  assign spi_ss_n_o = ss_n_q;
  // The TX register is the MOSI output register: its MSB is the live bit.
  assign spi_mosi_o = tx_q[63];

endmodule
